// File: rtl/seg_pkg.sv
// Shared seven-segment types and the active-high hex glyph table.
// Bit order is {g,f,e,d,c,b,a}; b and d use lowercase glyphs.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t seg_pol(input seg_t s, input logic al);
        return al ? ~s : s;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high segment pattern decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg_t       o_seg
);

    assign o_seg = SEG_HEX[i_nib];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display
// with frame-synchronous shadow capture, blink and PWM brightness.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_LOG2  = 14,
    parameter int BRIGHT_W   = 4,
    parameter int BLINK_LOG2 = 5,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk_100mhz,
    input  logic                      sys_rst,
    input  logic [4*NUM_DIGITS-1:0]   val_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [NUM_DIGITS-1:0]     blink_in,
    input  logic [BRIGHT_W-1:0]       bright_in,
    input  logic                      update_in,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [6:0]                cat_out,
    output logic                      dp_out,
    output logic                      frame_out
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
    localparam logic AL = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AL}};
    localparam seg_t CAT_OFF = seg_pol(SEG_BLANK, AL);

    logic [DIG_W-1:0]        r_digit;
    logic [SCAN_LOG2-1:0]    r_dwell;
    logic                    r_pend;
    logic [BLINK_LOG2:0]     r_blink_cnt;
    logic [4*NUM_DIGITS-1:0] r_val_sh;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [NUM_DIGITS-1:0]   r_blank_sh;
    logic [NUM_DIGITS-1:0]   r_blink_sh;

    logic [NUM_DIGITS-1:0]   r_an;
    seg_t                    r_cat;
    logic                    r_dp;
    logic                    r_frame;

    logic                    w_dwell_wrap;
    logic                    w_boundary;
    logic                    w_capture;
    logic                    w_blink_off;
    logic                    w_guard_ok;
    logic                    w_bright_ok;
    logic                    w_lit;
    logic [3:0]              w_nib;
    seg_t                    w_seg;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_dwell_wrap = &r_dwell;
    assign w_boundary   = w_dwell_wrap && (r_digit == LAST_DIG);
    assign w_capture    = w_boundary && (r_pend || update_in);
    assign w_blink_off  = r_blink_cnt[BLINK_LOG2];

    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            r_digit <= '0;
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
            if (w_dwell_wrap) begin
                r_digit <= (r_digit == LAST_DIG) ? '0 : r_digit + 1'b1;
            end
        end
    end

    // Requests merge into pend; the inputs present at the boundary win.
    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            r_pend <= 1'b0;
        end else if (w_boundary) begin
            r_pend <= 1'b0;
        end else if (update_in) begin
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            r_val_sh   <= '0;
            r_dp_sh    <= '0;
            r_blank_sh <= '1;
            r_blink_sh <= '0;
        end else if (w_capture) begin
            r_val_sh   <= val_in;
            r_dp_sh    <= dp_in;
            r_blank_sh <= blank_in;
            r_blink_sh <= blink_in;
        end
    end

    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            r_blink_cnt <= '0;
        end else if (w_boundary) begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Dwell slot 0 stays dark so the anode switch never ghosts.
    assign w_guard_ok  = (r_dwell != '0);
    assign w_bright_ok = (r_dwell[SCAN_LOG2-1 -: BRIGHT_W] <= bright_in);
    assign w_lit       = w_guard_ok && w_bright_ok &&
                         !r_blank_sh[r_digit] &&
                         !(r_blink_sh[r_digit] && w_blink_off);

    assign w_nib    = r_val_sh[4*r_digit +: 4];
    assign w_onehot = NUM_DIGITS'(1) << r_digit;

    hex_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            r_an    <= AN_OFF;
            r_cat   <= CAT_OFF;
            r_dp    <= AL;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_lit ? (w_onehot ^ AN_OFF) : AN_OFF;
            r_cat   <= w_lit ? seg_pol(w_seg, AL) : CAT_OFF;
            r_dp    <= AL ^ (w_lit & r_dp_sh[r_digit]);
            r_frame <= w_boundary;
        end
    end

    assign an_out    = r_an;
    assign cat_out   = r_cat;
    assign dp_out    = r_dp;
    assign frame_out = r_frame;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan at 8 digits, 16-cycle dwell,
// 2-bit brightness and a 2-frame blink half-period, active-low pins.
module tb_seven_seg_scan;

    localparam logic [6:0] HEXT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [31:0] val_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic [7:0]  blink_in;
    logic [1:0]  bright_in;
    logic        update_in;
    logic [7:0]  an_out;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic        frame_out;

    int unsigned cyc;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] e_val;
    logic [7:0]  e_dp, e_blank, e_blink;
    logic        m_pend;
    logic [15:0] exp_vec;
    logic        exp_frame;

    always #5 clk = ~clk;

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    seven_seg_scan #(
        .NUM_DIGITS (8),
        .SCAN_LOG2  (4),
        .BRIGHT_W   (2),
        .BLINK_LOG2 (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk_100mhz (clk),
        .sys_rst    (sys_rst),
        .val_in     (val_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .bright_in  (bright_in),
        .update_in  (update_in),
        .an_out     (an_out),
        .cat_out    (cat_out),
        .dp_out     (dp_out),
        .frame_out  (frame_out)
    );

    // Expected pins one edge after the scan is in state s (s edges since reset).
    function automatic logic [15:0] model(input int unsigned s, input logic [1:0] br);
        int unsigned p;
        int          d;
        int          w;
        logic        lit;
        logic        ph;
        logic [3:0]  nib;
        logic [7:0]  one;
        p   = s % 128;
        d   = int'(p / 16);
        w   = int'(p % 16);
        ph  = ((s >> 8) & 1) != 0;
        lit = (w != 0) && ((w / 4) <= int'(br)) && !e_blank[d] && !(e_blink[d] && ph);
        nib = e_val[4*d +: 4];
        one = 8'd1 << d;
        if (lit) return {~one, ~HEXT[nib], ~e_dp[d]};
        return {8'hFF, 7'h7F, 1'b1};
    endfunction

    task automatic model_reset();
        e_val   = '0;
        e_dp    = '0;
        e_blank = '1;
        e_blink = '0;
        m_pend  = 1'b0;
    endtask

    // Advance one clock, updating the reference shadows; called at a negedge.
    task automatic step();
        exp_vec   = model(cyc, bright_in);
        exp_frame = (cyc % 128) == 127;
        if ((cyc % 128) == 127) begin
            if (m_pend || update_in) begin
                e_val   = val_in;
                e_dp    = dp_in;
                e_blank = blank_in;
                e_blink = blink_in;
            end
            m_pend = 1'b0;
        end else if (update_in) begin
            m_pend = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first;
        int nf;
        sys_rst   = 1'b1;
        val_in    = '0;
        dp_in     = '0;
        blank_in  = '0;
        blink_in  = '0;
        bright_in = 2'd3;
        update_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({an_out, cat_out, dp_out, frame_out} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_pins got=%h exp=%h",
                     {an_out, cat_out, dp_out, frame_out}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end
        sys_rst = 1'b0;
        first = -1;
        nf = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if ({an_out, cat_out} !== {8'hFF, 7'h7F}) begin
                failures++;
                $display("FAIL reset_dark cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out}, {8'hFF, 7'h7F});
            end
            checks++;
            if (frame_out !== exp_frame) begin
                failures++;
                $display("FAIL reset_frame cyc=%0d got=%b exp=%b", cyc, frame_out, exp_frame);
            end
            if (frame_out === 1'b1) begin
                if (first < 0) first = int'(cyc);
                nf++;
            end
        end
        checks++;
        if (first != 128) begin
            failures++;
            $display("FAIL first_frame got=%0d exp=128", first);
        end
        checks++;
        if (nf != 2) begin
            failures++;
            $display("FAIL frame_count got=%0d exp=2", nf);
        end
    endtask

    task automatic test_single_update();
        int lc [8];
        int win;
        foreach (lc[d]) lc[d] = 0;
        win = -1;
        val_in    = 32'h76543210;
        dp_in     = 8'h80;
        blank_in  = 8'h00;
        blink_in  = 8'h00;
        bright_in = 2'd3;
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if ({an_out, cat_out, dp_out} !== exp_vec) begin
                failures++;
                $display("FAIL upd_pins cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out, dp_out}, exp_vec);
            end
            checks++;
            if (frame_out !== exp_frame) begin
                failures++;
                $display("FAIL upd_frame cyc=%0d got=%b exp=%b", cyc, frame_out, exp_frame);
            end
            if (win >= 0 && win < 128) begin
                for (int d = 0; d < 8; d++)
                    if (an_out == ~(8'd1 << d)) lc[d]++;
                if (an_out == 8'hFE) begin
                    checks++;
                    if (cat_out !== 7'h40) begin
                        failures++;
                        $display("FAIL digit0_glyph got=%h exp=40", cat_out);
                    end
                end
                if (an_out == 8'h7F) begin
                    checks++;
                    if ({cat_out, dp_out} !== {7'h78, 1'b0}) begin
                        failures++;
                        $display("FAIL digit7_glyph got=%h exp=%h", {cat_out, dp_out}, {7'h78, 1'b0});
                    end
                end
                win++;
            end
            if (win < 0 && frame_out === 1'b1) win = 0;
        end
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (lc[d] != 15) begin
                failures++;
                $display("FAIL lit_count d=%0d got=%0d exp=15", d, lc[d]);
            end
        end
    endtask

    task automatic test_brightness();
        int lc [8];
        int want;
        for (int b = 0; b < 2; b++) begin
            bright_in = 2'(b);
            want = (b == 0) ? 6 : 14;
            foreach (lc[d]) lc[d] = 0;
            for (int i = 0; i < 256; i++) begin
                step();
                checks++;
                if ({an_out, cat_out, dp_out} !== exp_vec) begin
                    failures++;
                    $display("FAIL bright_pins cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out, dp_out}, exp_vec);
                end
                for (int d = 0; d < 8; d++)
                    if (an_out == ~(8'd1 << d)) lc[d]++;
            end
            for (int d = 0; d < 8; d++) begin
                checks++;
                if (lc[d] != want) begin
                    failures++;
                    $display("FAIL bright_count b=%0d d=%0d got=%0d exp=%0d", b, d, lc[d], want);
                end
            end
        end
        bright_in = 2'd3;
    endtask

    task automatic test_merge();
        int seen;
        while ((cyc % 128) != 20) step();
        val_in    = 32'hFFFFFFFF;
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        repeat (5) step();
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        val_in    = 32'h89ABCDEF;
        seen = 0;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            step();
            checks++;
            if ({an_out, cat_out, dp_out} !== exp_vec) begin
                failures++;
                $display("FAIL merge_old cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out, dp_out}, exp_vec);
            end
            if (frame_out === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL merge_timeout got=0 exp=1");
        end
        for (int i = 0; i < 128; i++) begin
            step();
            checks++;
            if ({an_out, cat_out, dp_out} !== exp_vec) begin
                failures++;
                $display("FAIL merge_new cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out, dp_out}, exp_vec);
            end
            if (an_out == 8'hFE) begin
                checks++;
                if (cat_out !== 7'h0E) begin
                    failures++;
                    $display("FAIL merge_d0 got=%h exp=0e", cat_out);
                end
            end
            if (an_out == 8'h7F) begin
                checks++;
                if (cat_out !== 7'h00) begin
                    failures++;
                    $display("FAIL merge_d7 got=%h exp=00", cat_out);
                end
            end
        end
    endtask

    task automatic test_boundary_update();
        int lit0;
        lit0 = 0;
        while ((cyc % 128) != 127) step();
        val_in    = 32'h0000000A;
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        checks++;
        if (frame_out !== 1'b1) begin
            failures++;
            $display("FAIL bnd_frame got=%b exp=1", frame_out);
        end
        for (int i = 0; i < 128; i++) begin
            step();
            checks++;
            if ({an_out, cat_out, dp_out} !== exp_vec) begin
                failures++;
                $display("FAIL bnd_pins cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out, dp_out}, exp_vec);
            end
            if (an_out == 8'hFE) begin
                lit0++;
                checks++;
                if (cat_out !== 7'h08) begin
                    failures++;
                    $display("FAIL bnd_d0 got=%h exp=08", cat_out);
                end
            end
        end
        checks++;
        if (lit0 != 15) begin
            failures++;
            $display("FAIL bnd_lit got=%0d exp=15", lit0);
        end
    endtask

    task automatic test_blink();
        int c0;
        int c1;
        int k;
        int sum0;
        int seen;
        sum0 = 0;
        blink_in  = 8'h01;
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            step();
            if (frame_out === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL blink_timeout got=0 exp=1");
        end
        for (int f = 0; f < 4; f++) begin
            k = int'(cyc / 128);
            c0 = 0;
            c1 = 0;
            for (int i = 0; i < 128; i++) begin
                step();
                checks++;
                if ({an_out, cat_out, dp_out} !== exp_vec) begin
                    failures++;
                    $display("FAIL blink_pins cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out, dp_out}, exp_vec);
                end
                if (an_out == 8'hFE) c0++;
                if (an_out == 8'hFD) c1++;
            end
            sum0 += c0;
            checks++;
            if (c0 != ((((k >> 1) & 1) != 0) ? 0 : 15)) begin
                failures++;
                $display("FAIL blink_d0 k=%0d got=%0d", k, c0);
            end
            checks++;
            if (c1 != 15) begin
                failures++;
                $display("FAIL blink_d1 k=%0d got=%0d exp=15", k, c1);
            end
        end
        checks++;
        if (sum0 != 30) begin
            failures++;
            $display("FAIL blink_sum got=%0d exp=30", sum0);
        end
        blink_in = 8'h00;
    endtask

    task automatic test_reset_mid();
        int first;
        int lit0;
        first = -1;
        lit0 = 0;
        val_in = 32'h76543210;
        while ((cyc % 16) != 7) step();
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({an_out, cat_out, dp_out, frame_out} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=%h",
                     {an_out, cat_out, dp_out, frame_out}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end
        model_reset();
        @(negedge clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if ({an_out, cat_out, dp_out} !== {8'hFF, 7'h7F, 1'b1}) begin
                failures++;
                $display("FAIL rst_blank cyc=%0d got=%h", cyc, {an_out, cat_out, dp_out});
            end
            checks++;
            if (frame_out !== exp_frame) begin
                failures++;
                $display("FAIL rst_frame cyc=%0d got=%b exp=%b", cyc, frame_out, exp_frame);
            end
            if (frame_out === 1'b1 && first < 0) first = int'(cyc);
        end
        checks++;
        if (first != 128) begin
            failures++;
            $display("FAIL rst_first got=%0d exp=128", first);
        end
        update_in = 1'b1;
        step();
        update_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if ({an_out, cat_out, dp_out} !== exp_vec) begin
                failures++;
                $display("FAIL rst_upd cyc=%0d got=%h exp=%h", cyc, {an_out, cat_out, dp_out}, exp_vec);
            end
            if (an_out == 8'hFE) lit0++;
        end
        checks++;
        if (lit0 < 15) begin
            failures++;
            $display("FAIL rst_relit got=%0d exp>=15", lit0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_update();
        test_brightness();
        test_merge();
        test_boundary_update();
        test_blink();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
